parity_scan_engine: RTL
=======================

Name: parity_scan_engine

Overview:
Parametrised memory-integrity scanner that walks an external parity-protected memory and checks every entry's stored parity bit against its data word. It generalises the fixed 16-entry / 8-bit / even-parity address-walk-and-check path into a start/done controlled engine. The engine has a configurable data width and depth, selectable even/odd parity, pipelined synchronous reads, an error counter and first-error address capture. It sits between a control sequencer (start/done) and any synchronous-read memory bank.

Parameters:
DATA_W, 8, data word width in bits (parity bit is separate)
ADDR_W, 4, address width; scan depth N = 2**ADDR_W
ERR_CNT_W, 8, error counter width; counter saturates at all-ones

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  scan request, sampled only in IDLE
mode_odd  input  1  0 = even parity, 1 = odd parity; latched when start is accepted
mem_rd  output  1  read strobe to memory
mem_addr  output  ADDR_W  read address
mem_data  input  DATA_W  read data, valid the cycle after mem_rd
mem_par  input  1  stored parity bit, valid the cycle after mem_rd
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at scan end
pass  output  1  1 if err_count==0 at done; held until the next accepted start
err_count  output  ERR_CNT_W  number of failing entries, saturating
first_err_addr  output  ADDR_W  address of the first failing entry
first_err_valid  output  1  first_err_addr holds a captured value

Behaviour:
- Reset (synchronous, highest priority, any state): FSM goes to IDLE. All outputs are 0: mem_rd, mem_addr, busy, done, pass, err_count, first_err_addr, first_err_valid. Any in-flight read is discarded.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE: when start=1 at edge T, the engine latches mode_odd, clears err_count, first_err_valid, first_err_addr and pass, and enters SCAN.
- start while busy or in DONE: ignored, with no effect on the current scan.
- SCAN: in cycle T+1+k (k = 0..N-1), mem_rd=1 and mem_addr=k. After k=N-1 the FSM enters DRAIN with mem_rd=0. mem_addr holds its last value whenever mem_rd=0.
- Check pipeline: the data and parity for the read issued in cycle c are sampled at the end of cycle c+1. Entry k is evaluated in cycle T+2+k.
- Failure rule: an entry fails iff (XOR of mem_data) XOR mem_par XOR mode_odd_latched == 1.
  - Even mode: the stored bit must equal the XOR of the data bits.
  - Odd mode: the stored bit must equal the inverse of that XOR.
- On failure:
  - err_count increments by 1, saturating at 2**ERR_CNT_W-1 with no wrap.
  - If first_err_valid=0, first_err_addr=k and first_err_valid=1. Later failures do not overwrite it.
- DRAIN: lasts one cycle and evaluates entry N-1, then the FSM enters DONE.
- DONE: lasts one cycle (cycle T+N+2). done=1, busy=0, and pass=(err_count==0), including the final entry's result. The FSM then returns to IDLE.
- Total latency from start sampled to done is N+2 cycles (18 for defaults).
- Result persistence: err_count, first_err_addr, first_err_valid and pass hold their values in IDLE until the next accepted start.
- busy timing: high in SCAN and DRAIN, low in IDLE and DONE.
- A start sampled in the same cycle done=1 is ignored. The earliest restart is the first IDLE cycle.
- Address counter is ADDR_W wide with no wrap past N-1. The transition to DRAIN is decided on mem_addr==N-1.

Optional Feature:
PARITY_SCAN_STOP_ON_ERR_EN
- Defined: on the first failing entry k (evaluated in cycle T+2+k), the engine stops issuing reads from the next cycle. The read for k+1 already issued in that cycle is discarded and not checked. The FSM goes directly to DONE in cycle T+3+k. err_count=1, first_err_addr=k, pass=0. If k=N-1, the timing is identical to a normal scan.
- Undefined: the full scan always runs with N+2 latency, as described above.

Test Plan:
- Even mode, 16-entry memory with all parities correct (e.g. word 8'h1F, par 1), start at T -> mem_rd high for exactly 16 cycles, done at T+18, pass=1, err_count=0, first_err_valid=0.
- Same memory with parity bits of entries 3 and 9 flipped -> err_count=2, first_err_addr=3, first_err_valid=1, pass=0, done at T+18.
- All-correct even memory scanned with mode_odd=1 -> err_count=16, first_err_addr=0, pass=0. Rerun with mode_odd=0 -> counters cleared at start, pass=1.
- ERR_CNT_W=3, all entries bad -> err_count saturates at 7 (no wrap to 0). Pulse start at T+5 mid-scan -> no restart, done still at T+18.
- Assert reset for one cycle while mem_addr=5 -> next cycle all outputs 0 and FSM in IDLE. A fresh start then scans from addr 0 with full N+2 latency.
- With PARITY_SCAN_STOP_ON_ERR_EN and entry 4 bad -> last mem_rd has addr 5, done at T+7, err_count=1, first_err_addr=4, pass=0.

Source files
------------

// File: rtl/parity_scan_engine.sv
// ---------------------------------------------------------------------------
// parity_scan_engine
//
// Walks a synchronous-read, parity-protected memory from address 0 to
// 2**ADDR_W-1, checks each stored parity bit against its data word, and
// reports an error count, the first failing address and a pass flag.
//
// Timing (start sampled at edge T; the cycle after edge T is T+1):
//   cycle T+1+k : mem_rd=1, mem_addr=k        (k = 0..N-1)
//   cycle T+2+k : entry k evaluated (data returned by the memory)
//   cycle T+N+1 : DRAIN, evaluates entry N-1
//   cycle T+N+2 : DONE, done pulse, pass valid
//
// Optional build macro:
//   PARITY_SCAN_STOP_ON_ERR_EN - abort the scan on the first failing entry
//                                and go straight to DONE.
//
// Reset is synchronous and active-high and clears every output.
// ---------------------------------------------------------------------------
module parity_scan_engine #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode_odd,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  input  logic                 mem_par,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic                 first_err_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0]    LAST_ADDR = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  state_t              state;
  logic                mode_q;     // parity sense latched at start
  logic                chk_valid;  // memory data this cycle belongs to a read we issued
  logic [ADDR_W-1:0]   chk_addr;   // address of the entry being evaluated
  logic                entry_fail;
  logic                stop_now;
  logic [ERR_CNT_W-1:0] err_count_next;

  // Evaluate the returning entry and form the saturating next error count.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    entry_fail     = chk_valid & ((^mem_data) ^ mem_par ^ mode_q);
    err_count_next = err_count;
    if (entry_fail && (err_count != ERR_MAX)) begin
      err_count_next = err_count + 1'b1;
    end
  end

`ifdef PARITY_SCAN_STOP_ON_ERR_EN
  // A failure seen while reads are still being issued ends the scan early;
  // a failure on the last entry (seen in DRAIN) finishes normally.
  assign stop_now = entry_fail && (state == SCAN);
`else
  assign stop_now = 1'b0;
`endif

  // Check pipeline: track which issued read the memory is answering this cycle.
  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      chk_valid <= 1'b0;
      chk_addr  <= '0;
    end else begin
      // On an early stop, the read issued alongside the failing check is dropped.
      chk_valid <= mem_rd && !stop_now;
      chk_addr  <= mem_addr;
    end
  end

  // Scan controller with registered outputs and result bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      mode_q          <= 1'b0;
      mem_rd          <= 1'b0;
      mem_addr        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_addr  <= '0;
      first_err_valid <= 1'b0;
    end else begin
      // Results accumulate while checked entries are returning.
      if ((state == SCAN) || (state == DRAIN)) begin
        err_count <= err_count_next;
        if (entry_fail && !first_err_valid) begin
          first_err_addr  <= chk_addr;
          first_err_valid <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q          <= mode_odd;
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            mem_rd          <= 1'b1;
            mem_addr        <= '0;
            busy            <= 1'b1;
            state           <= SCAN;
          end
        end

        SCAN: begin
          if (stop_now) begin
            mem_rd <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= 1'b0;
            state  <= DONE;
          end else if (mem_addr == LAST_ADDR) begin
            // Address holds at N-1; the last entry is still in flight.
            mem_rd <= 1'b0;
            state  <= DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end

        DRAIN: begin
          // The final entry's result is folded into pass here.
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count_next == '0);
          state <= DONE;
        end

        DONE: begin
          // start is not looked at here; the earliest restart is from IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
